dl_shift_pipe: RTL and testbench
================================

# dl_shift_pipe

Pipelined, elastic shift execution unit for the integer datapath. Accepts a shift operation (SLL, SRL, SRA or pass-through), operand, shift amount and destination tag over a valid/ready handshake, registers them, computes the result with a combinational barrel-shift stage, and registers the result toward writeback. Sits between the issue stage and the writeback arbiter. Sustains one operation per cycle with fixed 2-cycle latency when unstalled.

## Interface

- NUM_BITS, 32, operand/result width; power of two, ≥ 2
- TAG_BITS, 5, width of the pass-through destination tag
- NUM_SHIFT_BITS, $clog2(NUM_BITS), local, shift-amount width

- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  upstream operation valid
- in_ready  output  1  unit can accept this cycle
- in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 pass-through
- in_data  input  NUM_BITS  operand
- in_shamt  input  NUM_SHIFT_BITS  shift amount
- in_tag  input  TAG_BITS  destination tag, carried unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  NUM_BITS  shift result
- out_tag  output  TAG_BITS  tag of out_data
- busy  output  1  any pipeline/skid entry valid

## Operation

- Transfer on a port occurs in a cycle where valid && ready at the rising edge.
- Stage S1: registers op, data, shamt, tag on input transfer; s1_valid set.
- Stage S2: registers result and tag from S1; drives out_valid/out_data/out_tag directly from flops.
- Advance rules: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv. S1 moves into S2 when s1_valid && s2_adv. S2 clears on output transfer unless refilled the same cycle.
- Arithmetic (on S1 contents, combinational):
  - SLL: data << shamt, zero fill.
  - SRL: data >> shamt, zero fill.
  - SRA: data >> shamt, vacated bits = data[NUM_BITS-1].
  - 10: result = data; shamt ignored.
  - shamt = 0 → result = data for all ops. Full range 0..NUM_BITS-1 legal; no wrap or saturation.
- Ordering: strictly in order; no drop, no duplication.
- While stalled (out_valid && !out_ready), out_data/out_tag held stable.
- busy = s1_valid || s2_valid (|| skid_valid when configured).

## Timing

- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_tag=0, busy=0, all valid flags 0, data flops 0. in_ready=1 from the first cycle after deassertion. Reset mid-operation discards all in-flight entries; no stale result appears after release.
- Latency: input transfer in cycle N → out_valid in cycle N+2 when unstalled.
- Throughput: one transfer per cycle with out_ready held high.
- Capacity: 2 entries (S1, S2) without skid; 3 with skid.
- Simultaneous input transfer and output transfer on a full pipe: legal, occupancy unchanged.

## Configuration

- DL_SHIFT_PIPE_SKID_EN defined: one-entry skid register in front of S1; in_ready = !skid_valid, driven purely from a flop (no combinational path from out_ready). On a stall, the entry accepted while in_ready was high lands in the skid; drained into S1 before new input. Latency unchanged when skid empty; +1 cycle per entry while skid occupied.
- Not defined: no skid; in_ready = s1_adv, combinational from out_ready.

## Test plan

- SRA in_data=0x8000_0000, shamt=31 → out_data=0xFFFF_FFFF, out_tag preserved, out_valid exactly 2 cycles after accept; same with SRL → 0x0000_0001; SLL 0x0000_0001 shamt=31 → 0x8000_0000.
- shamt=0 for SLL/SRL/SRA and op=10 with shamt=7, data=0xDEAD_BEEF → out_data=0xDEAD_BEEF each.
- 4 back-to-back ops, tags 1..4, out_ready=1 → results on 4 consecutive cycles starting cycle 2, tags 1..4 in order.
- Continuous in_valid stream, out_ready low for 5 cycles → in_ready drops after 2 (3 with skid) accepts, out_data/out_tag stable, all entries delivered in order after out_ready returns, none lost or repeated.
- rst_n pulsed low while 2 ops in flight → out_valid/busy 0 immediately; after release in_ready=1, no output until a new op accepted.
- With DL_SHIFT_PIPE_SKID_EN: toggle out_ready every cycle under full input load → in_ready never combinationally follows out_ready; ordering and data match a reference model.

Source files
------------

// File: rtl/dl_shift_pipe_if.sv
// Handshake/bus bundle for the dl_shift_pipe shift unit.
// slave: the shift unit's view. master: the issue/writeback side's view.
interface dl_shift_pipe_if #(
   parameter int NUM_BITS = 32,
   parameter int TAG_BITS = 5
);
   localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

   logic                      in_valid;
   logic                      in_ready;
   logic [1:0]                in_op;
   logic [NUM_BITS-1:0]       in_data;
   logic [NUM_SHIFT_BITS-1:0] in_shamt;
   logic [TAG_BITS-1:0]       in_tag;
   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_BITS-1:0]       out_data;
   logic [TAG_BITS-1:0]       out_tag;
   logic                      busy;

   modport slave (
      input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, busy
   );

   modport master (
      output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, busy
   );
endinterface

// File: rtl/dl_shift_pipe.sv
// dl_shift_pipe: two-stage elastic shift unit (SLL/SRL/SRA/pass-through).
// S1 holds the accepted operation, the barrel shift is combinational on S1,
// S2 holds the result and drives the output port straight from flops.
// Optional macro DL_SHIFT_PIPE_SKID_EN adds a one-entry skid register in
// front of S1 so in_ready comes from a flop instead of from out_ready.
module dl_shift_pipe #(
   parameter int NUM_BITS = 32,
   parameter int TAG_BITS = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   dl_shift_pipe_if.slave    bus
);
   localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_PASS = 2'b10;
   localparam logic [1:0] OP_SRA  = 2'b11;

   logic                      s1_valid;
   logic [1:0]                s1_op;
   logic [NUM_BITS-1:0]       s1_data;
   logic [NUM_SHIFT_BITS-1:0] s1_shamt;
   logic [TAG_BITS-1:0]       s1_tag;

   logic                      s2_valid;
   logic [NUM_BITS-1:0]       s2_data;
   logic [TAG_BITS-1:0]       s2_tag;

   logic                      s2_adv;
   logic                      s1_adv;
   logic                      in_fire;
   logic                      skid_busy;

   // next entry offered to S1 (skid contents take priority over new input)
   logic                      src_valid;
   logic [1:0]                src_op;
   logic [NUM_BITS-1:0]       src_data;
   logic [NUM_SHIFT_BITS-1:0] src_shamt;
   logic [TAG_BITS-1:0]       src_tag;

   logic [NUM_BITS-1:0]        result;
   logic signed [NUM_BITS-1:0] s1_sdata;

   assign s2_adv = !s2_valid || bus.out_ready;
   assign s1_adv = !s1_valid || s2_adv;

`ifdef DL_SHIFT_PIPE_SKID_EN
   logic                      skid_valid;
   logic [1:0]                skid_op;
   logic [NUM_BITS-1:0]       skid_data;
   logic [NUM_SHIFT_BITS-1:0] skid_shamt;
   logic [TAG_BITS-1:0]       skid_tag;

   // Ready depends only on the skid flop, which breaks the out_ready -> in_ready path.
   assign bus.in_ready = !skid_valid;
   assign in_fire      = bus.in_valid && !skid_valid;
   assign skid_busy    = skid_valid;

   assign src_valid = skid_valid || in_fire;
   assign src_op    = skid_valid ? skid_op    : bus.in_op;
   assign src_data  = skid_valid ? skid_data  : bus.in_data;
   assign src_shamt = skid_valid ? skid_shamt : bus.in_shamt;
   assign src_tag   = skid_valid ? skid_tag   : bus.in_tag;

   // Skid captures an accepted op that S1 cannot take; it drains before new input is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid <= 1'b0;
         skid_op    <= '0;
         skid_data  <= '0;
         skid_shamt <= '0;
         skid_tag   <= '0;
      end else if (skid_valid) begin
         if (s1_adv) begin
            skid_valid <= 1'b0;
         end
      end else if (in_fire && !s1_adv) begin
         skid_valid <= 1'b1;
         skid_op    <= bus.in_op;
         skid_data  <= bus.in_data;
         skid_shamt <= bus.in_shamt;
         skid_tag   <= bus.in_tag;
      end
   end
`else
   assign bus.in_ready = s1_adv;
   assign in_fire      = bus.in_valid && s1_adv;
   assign skid_busy    = 1'b0;

   assign src_valid = in_fire;
   assign src_op    = bus.in_op;
   assign src_data  = bus.in_data;
   assign src_shamt = bus.in_shamt;
   assign src_tag   = bus.in_tag;
`endif

   // S1: take the next operation whenever S1 is free or emptying into S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_data  <= '0;
         s1_shamt <= '0;
         s1_tag   <= '0;
      end else if (s1_adv) begin
         s1_valid <= src_valid;
         if (src_valid) begin
            s1_op    <= src_op;
            s1_data  <= src_data;
            s1_shamt <= src_shamt;
            s1_tag   <= src_tag;
         end
      end
   end

   assign s1_sdata = s1_data;

   // Barrel shift on S1 contents; shamt of 0 naturally yields the operand.
   always_comb begin
      result = s1_data;
      case (s1_op)
         OP_SLL:  result = s1_data << s1_shamt;
         OP_SRL:  result = s1_data >> s1_shamt;
         OP_SRA:  result = s1_sdata >>> s1_shamt;
         OP_PASS: result = s1_data;
         default: result = s1_data;
      endcase
   end

   // S2: result register; holds steady while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_tag   <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= result;
            s2_tag  <= s1_tag;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_tag   = s2_tag;
   assign bus.busy      = s1_valid || s2_valid || skid_busy;

endmodule

// File: tb/tb_dl_shift_pipe.sv
// Self-checking bench for dl_shift_pipe (NUM_BITS=32, TAG_BITS=5).
module tb_dl_shift_pipe;
   localparam int NB = 32;
   localparam int TB = 5;
`ifdef DL_SHIFT_PIPE_SKID_EN
   localparam int CAP = 3;
`else
   localparam int CAP = 2;
`endif

   logic clk;
   logic rst_n;

   dl_shift_pipe_if #(.NUM_BITS(NB), .TAG_BITS(TB)) bus ();

   dl_shift_pipe #(.NUM_BITS(NB), .TAG_BITS(TB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]    op;
      logic [NB-1:0] data;
      logic [4:0]    shamt;
      logic [TB-1:0] tag;
      logic [NB-1:0] exp;
   } vec_t;

   typedef struct {
      logic [NB-1:0] data;
      logic [TB-1:0] tag;
   } res_t;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   bit   have_pay = 0;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: shifts expressed as multiply / floor-divide by 2**s.
   function automatic logic [NB-1:0] ref_shift(input logic [1:0] op, input logic [NB-1:0] d, input int s);
      longint p, v, r;
      p = 1;
      repeat (s) p = p * 2;
      case (op)
         2'b00: r = longint'(d) * p;
         2'b01: r = longint'(d) / p;
         2'b11: begin
            v = d[NB-1] ? longint'(d) - 64'sh1_0000_0000 : longint'(d);
            if (v < 0) r = (v - (p - 1)) / p;
            else       r = v / p;
         end
         default: r = longint'(d);
      endcase
      return r[NB-1:0];
   endfunction

   task automatic new_payload();
      bus.in_op   = 2'($urandom_range(0, 3));
      bus.in_data = $urandom;
      case ($urandom_range(0, 3))
         0:       bus.in_shamt = 5'd0;
         1:       bus.in_shamt = 5'd31;
         default: bus.in_shamt = 5'($urandom_range(0, 31));
      endcase
      bus.in_tag = 5'($urandom_range(0, 31));
      have_pay = 1;
   endtask

   // One clock: drive, sample just before the edge, update scoreboard, step.
   task automatic cycle(input bit v, input bit r, output bit fired);
      bit   in_f, out_f;
      res_t e;
      if (!have_pay) new_payload();
      bus.in_valid  = v;
      bus.out_ready = r;
      #1;
`ifdef DL_SHIFT_PIPE_SKID_EN
      begin
         logic a, b;
         a = bus.in_ready;
         bus.out_ready = !r;
         #1;
         b = bus.in_ready;
         bus.out_ready = r;
         #1;
         chk("in_ready_indep_of_out_ready", 64'(b), 64'(a));
      end
`endif
      chk("busy_vs_occupancy", 64'(bus.busy), 64'(exp_q.size() != 0));
      if (exp_q.size() > CAP) chk("occupancy_le_cap", 64'(exp_q.size()), 64'(CAP));
      in_f  = v && bus.in_ready;
      out_f = bus.out_valid && r;
      if (out_f) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", 64'(bus.out_data), 64'(e.data));
            chk("sb_tag", 64'(bus.out_tag), 64'(e.tag));
         end
      end
      if (in_f) begin
         e.data = ref_shift(bus.in_op, bus.in_data, int'(bus.in_shamt));
         e.tag  = bus.in_tag;
         exp_q.push_back(e);
         have_pay = 0;
      end
      fired = in_f;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit f;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, 1'b1, f);
      if (exp_q.size() > 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      chk("drained_out_valid", 64'(bus.out_valid), 64'(0));
   endtask

   initial begin
      bit   f;
      int   acc;
      bit   have_cap;
      logic [NB-1:0] cap_data;
      logic [TB-1:0] cap_tag;

      vecs[0]  = '{2'b11, 32'h8000_0000, 5'd31, 5'd3,  32'hFFFF_FFFF};
      vecs[1]  = '{2'b01, 32'h8000_0000, 5'd31, 5'd4,  32'h0000_0001};
      vecs[2]  = '{2'b00, 32'h0000_0001, 5'd31, 5'd5,  32'h8000_0000};
      vecs[3]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  5'd6,  32'hDEAD_BEEF};
      vecs[4]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  5'd7,  32'hDEAD_BEEF};
      vecs[5]  = '{2'b11, 32'hDEAD_BEEF, 5'd0,  5'd8,  32'hDEAD_BEEF};
      vecs[6]  = '{2'b10, 32'hDEAD_BEEF, 5'd7,  5'd9,  32'hDEAD_BEEF};
      vecs[7]  = '{2'b00, 32'hDEAD_BEEF, 5'd4,  5'd10, 32'hEADB_EEF0};
      vecs[8]  = '{2'b01, 32'hDEAD_BEEF, 5'd4,  5'd11, 32'h0DEA_DBEE};
      vecs[9]  = '{2'b11, 32'hDEAD_BEEF, 5'd4,  5'd12, 32'hFDEA_DBEE};
      vecs[10] = '{2'b11, 32'h7FFF_FFFF, 5'd31, 5'd13, 32'h0000_0000};
      vecs[11] = '{2'b11, 32'h4000_0000, 5'd1,  5'd31, 32'h2000_0000};

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_data = '0;
      bus.in_shamt = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_out_data", 64'(bus.out_data), 64'(0));
      chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

      // directed vectors, each checked for exact 2-cycle latency
      for (int i = 0; i < 12; i++) begin
         bus.in_valid = 1'b1; bus.out_ready = 1'b1;
         bus.in_op = vecs[i].op; bus.in_data = vecs[i].data;
         bus.in_shamt = vecs[i].shamt; bus.in_tag = vecs[i].tag;
         #1;
         chk("vec_accept_ready", 64'(bus.in_ready), 64'(1));
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         chk("vec_not_early", 64'(bus.out_valid), 64'(0));
         @(posedge clk); #1;
         chk("vec_valid_at_2", 64'(bus.out_valid), 64'(1));
         chk("vec_data", 64'(bus.out_data), 64'(vecs[i].exp));
         chk("vec_tag", 64'(bus.out_tag), 64'(vecs[i].tag));
         @(posedge clk); #1;
      end

      // four back-to-back ops, results on four consecutive cycles
      for (int c = 0; c < 6; c++) begin
         bus.in_valid = (c < 4); bus.out_ready = 1'b1;
         bus.in_op = 2'b00; bus.in_data = 32'h1;
         bus.in_shamt = 5'(c); bus.in_tag = 5'(c + 1);
         @(posedge clk); #1;
         if (c >= 1 && c <= 4) begin
            chk("b2b_valid", 64'(bus.out_valid), 64'(1));
            chk("b2b_tag", 64'(bus.out_tag), 64'(c));
            chk("b2b_data", 64'(bus.out_data), 64'(ref_shift(2'b00, 32'h1, c - 1)));
         end else if (c == 5) begin
            chk("b2b_end_valid", 64'(bus.out_valid), 64'(0));
         end
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;

      // stall with continuous input: capacity and output stability
      have_pay = 0; acc = 0; have_cap = 0; cap_data = '0; cap_tag = '0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, f);
         if (f) acc++;
         if (bus.out_valid) begin
            if (have_cap) begin
               chk("stall_hold_data", 64'(bus.out_data), 64'(cap_data));
               chk("stall_hold_tag", 64'(bus.out_tag), 64'(cap_tag));
            end else begin
               have_cap = 1; cap_data = bus.out_data; cap_tag = bus.out_tag;
            end
         end
      end
      chk("stall_accepts", 64'(acc), 64'(CAP));
      chk("stall_in_ready_low", 64'(bus.in_ready), 64'(0));
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, f);
      drain();

      // randomized traffic: toggling out_ready, then random back-pressure
      for (int i = 0; i < 400; i++) begin
         if (i < 200) cycle(1'b1, 1'(i % 2), f);
         else         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, f);
      end
      drain();

      // reset with two ops in flight
      cycle(1'b1, 1'b0, f);
      cycle(1'b1, 1'b0, f);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("midrst_busy", 64'(bus.busy), 64'(0));
      exp_q.delete();
      have_pay = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
         cycle(1'b0, 1'b1, f);
         chk("midrst_no_stale", 64'(bus.out_valid), 64'(0));
      end
      cycle(1'b1, 1'b1, f);
      chk("midrst_new_accept", 64'(f), 64'(1));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
